// File: rtl/dmem_rmw_ctrl.sv
// dmem_rmw_ctrl
//   Data-memory access controller between the core MEM stage and a word-only,
//   combinational-read RAM port. It provides byte/halfword loads with sign or
//   zero extension, and implements sub-word stores as read-modify-write.
//   Byte order inside a word is big-endian: offset 0 = bits[31:24].
//
// Parameters
//   MISALIGN_ERR : 1 = misaligned half/word access is an error (no RAM write)
//                  0 = low address bits are forced to 0 for half/word
//   IDLE_ZERO    : 1 = RAM address/write data driven 0 while ram_ce_o is 0
//                  0 = RAM address/write data hold the latched values
//
// Ports
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   req_i / ready_o        request valid / block idle and able to accept
//   addr_i, we_i, size_i   byte address, store flag, 00 byte 01 half 10 word
//   unsigned_i             zero-extend (1) or sign-extend (0) sub-word loads
//   wdata_i                right-aligned store data
//   valid_o, err_o         one-cycle response pulse, error qualified by valid
//   rdata_o                registered, right-aligned, extended load result
//   ram_ce_o, ram_we_o     RAM enable / word write enable
//   ram_addr_o             word-aligned RAM address
//   ram_wdata_o            full word written to RAM
//   ram_rdata_i            combinational RAM read data

module dmem_rmw_ctrl #(
    parameter bit MISALIGN_ERR = 1'b1,
    parameter bit IDLE_ZERO    = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    output logic        ready_o,
    input  logic [31:0] addr_i,
    input  logic        we_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [31:0] wdata_i,
    output logic        valid_o,
    output logic        err_o,
    output logic [31:0] rdata_o,
    output logic        ram_ce_o,
    output logic        ram_we_o,
    output logic [31:0] ram_addr_o,
    output logic [31:0] ram_wdata_o,
    input  logic [31:0] ram_rdata_i
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_READ,
        S_WRITE,
        S_RESP
    } state_t;

    state_t      r_state;
    logic [31:0] r_addr;
    logic        r_we;
    logic [1:0]  r_size;
    logic        r_uns;
    logic [31:0] r_wdata;
    logic [31:0] r_merge;

    logic        w_accept;
    logic        w_err;
    logic [31:0] w_addr_al;
    logic [1:0]  w_off;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load;
    logic [31:0] w_wword;

    assign ready_o  = (r_state == S_IDLE);
    assign w_accept = req_i && ready_o;
    assign w_off    = r_addr[1:0];

    // Error decode and address alignment on the raw request inputs
    always_comb begin
        w_err = (size_i == 2'b11);
        if (MISALIGN_ERR) begin
            if (size_i == 2'b01 && addr_i[0])
                w_err = 1'b1;
            if (size_i == 2'b10 && addr_i[1:0] != 2'b00)
                w_err = 1'b1;
        end
        case (size_i)
            2'b01:   w_addr_al = {addr_i[31:1], 1'b0};
            2'b10:   w_addr_al = {addr_i[31:2], 2'b00};
            default: w_addr_al = addr_i;
        endcase
    end

    // Load lane extraction and extension
    always_comb begin
        case (w_off)
            2'd0:    w_byte = ram_rdata_i[31:24];
            2'd1:    w_byte = ram_rdata_i[23:16];
            2'd2:    w_byte = ram_rdata_i[15:8];
            default: w_byte = ram_rdata_i[7:0];
        endcase
        w_half = w_off[1] ? ram_rdata_i[15:0] : ram_rdata_i[31:16];
        case (r_size)
            2'b00:   w_load = r_uns ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
            2'b01:   w_load = r_uns ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
            default: w_load = ram_rdata_i;
        endcase
    end

    // Write word: whole latched word for word stores, otherwise the word read
    // in READ with only the addressed lane replaced
    always_comb begin
        w_wword = r_merge;
        case (r_size)
            2'b00: begin
                case (w_off)
                    2'd0:    w_wword[31:24] = r_wdata[7:0];
                    2'd1:    w_wword[23:16] = r_wdata[7:0];
                    2'd2:    w_wword[15:8]  = r_wdata[7:0];
                    default: w_wword[7:0]   = r_wdata[7:0];
                endcase
            end
            2'b01: begin
                if (w_off[1])
                    w_wword[15:0]  = r_wdata[15:0];
                else
                    w_wword[31:16] = r_wdata[15:0];
            end
            default: w_wword = r_wdata;
        endcase
    end

    assign ram_addr_o  = (IDLE_ZERO && !ram_ce_o) ? '0 : {r_addr[31:2], 2'b00};
    assign ram_wdata_o = (IDLE_ZERO && !ram_ce_o) ? '0 : w_wword;

    // ram_ce_o/ram_we_o/valid_o are registered: they are set on the edge that
    // enters the state in which they must be visible.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state  <= S_IDLE;
            r_addr   <= '0;
            r_we     <= 1'b0;
            r_size   <= '0;
            r_uns    <= 1'b0;
            r_wdata  <= '0;
            r_merge  <= '0;
            valid_o  <= 1'b0;
            err_o    <= 1'b0;
            rdata_o  <= '0;
            ram_ce_o <= 1'b0;
            ram_we_o <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_addr  <= w_addr_al;
                        r_we    <= we_i;
                        r_size  <= size_i;
                        r_uns   <= unsigned_i;
                        r_wdata <= wdata_i;
                        if (w_err) begin
                            r_state <= S_RESP;
                            valid_o <= 1'b1;
                            err_o   <= 1'b1;
                            rdata_o <= '0;
                        end else if (!we_i) begin
                            r_state  <= S_LOAD;
                            ram_ce_o <= 1'b1;
                        end else if (size_i == 2'b10) begin
                            r_state  <= S_WRITE;
                            ram_ce_o <= 1'b1;
                            ram_we_o <= 1'b1;
                        end else begin
                            r_state  <= S_READ;
                            ram_ce_o <= 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    rdata_o  <= w_load;
                    ram_ce_o <= 1'b0;
                    valid_o  <= 1'b1;
                    r_state  <= S_RESP;
                end
                S_READ: begin
                    r_merge  <= ram_rdata_i;
                    ram_we_o <= 1'b1;
                    r_state  <= S_WRITE;
                end
                S_WRITE: begin
                    ram_ce_o <= 1'b0;
                    ram_we_o <= 1'b0;
                    valid_o  <= 1'b1;
                    r_state  <= S_RESP;
                end
                S_RESP: begin
                    valid_o <= 1'b0;
                    err_o   <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    ram_ce_o <= 1'b0;
                    ram_we_o <= 1'b0;
                    valid_o  <= 1'b0;
                    err_o    <= 1'b0;
                    r_state  <= S_IDLE;
                end
            endcase
        end
    end

    // r_we is latched with the request for completeness of the captured
    // transaction; the FSM path already encodes the store/load decision.
    logic w_unused;
    assign w_unused = r_we;

endmodule

// File: tb/tb_dmem_rmw_ctrl.sv
module tb_dmem_rmw_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        req_i = 1'b0;
    logic        ready_o;
    logic [31:0] addr_i = '0;
    logic        we_i = 1'b0;
    logic [1:0]  size_i = '0;
    logic        unsigned_i = 1'b0;
    logic [31:0] wdata_i = '0;
    logic        valid_o;
    logic        err_o;
    logic [31:0] rdata_o;
    logic        ram_ce_o;
    logic        ram_we_o;
    logic [31:0] ram_addr_o;
    logic [31:0] ram_wdata_o;
    logic [31:0] ram_rdata_i;

    int n_checks = 0;
    int n_errors = 0;

    // RAM model: combinational read, write captured at the clock edge
    logic [31:0] mem [0:255];
    logic        tb_wr = 1'b0;
    logic [7:0]  tb_wr_idx = '0;
    logic [31:0] tb_wr_data = '0;
    int          ce_cnt = 0;
    int          we_cnt = 0;

    assign ram_rdata_i = mem[ram_addr_o[9:2]];

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) begin
        if (tb_wr)
            mem[tb_wr_idx] <= tb_wr_data;
        else if (ram_ce_o && ram_we_o)
            mem[ram_addr_o[9:2]] <= ram_wdata_o;
        if (ram_ce_o) ce_cnt <= ce_cnt + 1;
        if (ram_we_o) we_cnt <= we_cnt + 1;
    end

    dmem_rmw_ctrl #(
        .MISALIGN_ERR(1'b1),
        .IDLE_ZERO(1'b1)
    ) dut (
        .clk_i(clk_i),
        .rst_ni(rst_ni),
        .req_i(req_i),
        .ready_o(ready_o),
        .addr_i(addr_i),
        .we_i(we_i),
        .size_i(size_i),
        .unsigned_i(unsigned_i),
        .wdata_i(wdata_i),
        .valid_o(valid_o),
        .err_o(err_o),
        .rdata_o(rdata_o),
        .ram_ce_o(ram_ce_o),
        .ram_we_o(ram_we_o),
        .ram_addr_o(ram_addr_o),
        .ram_wdata_o(ram_wdata_o),
        .ram_rdata_i(ram_rdata_i)
    );

    // All tasks start and end 1 time unit after a rising edge
    task automatic preload(input logic [31:0] byte_addr, input logic [31:0] data);
        tb_wr      = 1'b1;
        tb_wr_idx  = byte_addr[9:2];
        tb_wr_data = data;
        @(posedge clk_i); #1;
        tb_wr = 1'b0;
    endtask

    // Issue one request; report cycles from accept edge to valid (-1 = none)
    task automatic issue(input logic [31:0] a, input logic w, input logic [1:0] s,
                         input logic u, input logic [31:0] d,
                         output int lat, output logic e, output int nce, output int nwe);
        int  ce0, we0;
        logic found;
        lat = -1; e = 1'b0; found = 1'b0;
        ce0 = ce_cnt; we0 = we_cnt;
        req_i = 1'b1; addr_i = a; we_i = w; size_i = s; unsigned_i = u; wdata_i = d;
        @(posedge clk_i); #1;
        // scramble inputs: the block must work from its latched copy
        req_i = 1'b0; addr_i = 32'hFFFF_FFFF; we_i = ~w; size_i = ~s;
        unsigned_i = ~u; wdata_i = ~d;
        for (int k = 1; k <= 8; k++) begin
            if (!found && valid_o) begin
                found = 1'b1; lat = k; e = err_o;
            end
            if (!found) begin
                @(posedge clk_i); #1;
            end
        end
        @(posedge clk_i); #1;
        nce = ce_cnt - ce0;
        nwe = we_cnt - we0;
    endtask

    task automatic test_reset;
        #12;
        n_checks++;
        if (valid_o !== 1'b0 || err_o !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_valid_err: got %b/%b want 0/0", valid_o, err_o);
        end
        n_checks++;
        if (rdata_o !== 32'h0) begin
            n_errors++;
            $display("FAIL reset_rdata: got %h want 00000000", rdata_o);
        end
        n_checks++;
        if (ram_ce_o !== 1'b0 || ram_we_o !== 1'b0 || ram_addr_o !== 32'h0 || ram_wdata_o !== 32'h0) begin
            n_errors++;
            $display("FAIL reset_ram: got ce=%b we=%b addr=%h wd=%h want all 0",
                     ram_ce_o, ram_we_o, ram_addr_o, ram_wdata_o);
        end
        rst_ni = 1'b1;
        @(posedge clk_i); #1;
        n_checks++;
        if (ready_o !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_ready: got %b want 1", ready_o);
        end
    endtask

    task automatic test_load;
        logic [31:0] va [11] = '{32'h12, 32'h10, 32'h13, 32'h20, 32'h20, 32'h22,
                                 32'h20, 32'h20, 32'h21, 32'h20, 32'h20};
        logic [1:0]  vs [11] = '{2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01,
                                 2'b01, 2'b01, 2'b00, 2'b10, 2'b10};
        logic        vu [11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
                                 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [31:0] ve [11] = '{32'h00000033, 32'h00001122, 32'h00000044,
                                 32'hFFFFFF80, 32'h00000080, 32'h00007F01,
                                 32'hFFFF80FF, 32'h000080FF, 32'hFFFFFFFF,
                                 32'h80FF7F01, 32'h80FF7F01};
        int lat, nce, nwe;
        logic e;
        preload(32'h10, 32'h11223344);
        preload(32'h20, 32'h80FF7F01);
        for (int i = 0; i < 11; i++) begin
            issue(va[i], 1'b0, vs[i], vu[i], 32'h0, lat, e, nce, nwe);
            n_checks++;
            if (lat !== 2 || e !== 1'b0 || nce !== 1 || nwe !== 0) begin
                n_errors++;
                $display("FAIL load_timing[%0d]: got lat=%0d err=%b ce=%0d we=%0d want 2/0/1/0",
                         i, lat, e, nce, nwe);
            end
            n_checks++;
            if (rdata_o !== ve[i]) begin
                n_errors++;
                $display("FAIL load_data[%0d]: got %h want %h", i, rdata_o, ve[i]);
            end
        end
    endtask

    task automatic test_store;
        logic [31:0] va [7] = '{32'h31, 32'h32, 32'h30, 32'h33, 32'h30, 32'h32, 32'h30};
        logic [1:0]  vs [7] = '{2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b10};
        logic [31:0] vd [7] = '{32'hFFFFFF5A, 32'hABCD1234, 32'h0000BEEF, 32'h00000077,
                                32'h00000011, 32'h123456E0, 32'hCAFEF00D};
        logic [31:0] ve [7] = '{32'hAA5ACCDD, 32'hAABB1234, 32'hBEEFCCDD, 32'hAABBCC77,
                                32'h11BBCCDD, 32'hAABBE0DD, 32'hCAFEF00D};
        int          vl [7] = '{3, 3, 3, 3, 3, 3, 2};
        int lat, nce, nwe;
        logic e;
        preload(32'h34, 32'h55667788);
        for (int i = 0; i < 7; i++) begin
            preload(32'h30, 32'hAABBCCDD);
            issue(va[i], 1'b1, vs[i], 1'b0, vd[i], lat, e, nce, nwe);
            n_checks++;
            if (lat !== vl[i] || e !== 1'b0 || nwe !== 1 || nce !== vl[i] - 1) begin
                n_errors++;
                $display("FAIL store_timing[%0d]: got lat=%0d err=%b ce=%0d we=%0d want %0d/0/%0d/1",
                         i, lat, e, nce, nwe, vl[i], vl[i] - 1);
            end
            n_checks++;
            if (mem[8'h0C] !== ve[i]) begin
                n_errors++;
                $display("FAIL store_data[%0d]: got %h want %h", i, mem[8'h0C], ve[i]);
            end
        end
        n_checks++;
        if (mem[8'h0D] !== 32'h55667788) begin
            n_errors++;
            $display("FAIL store_neighbour: got %h want 55667788", mem[8'h0D]);
        end
        // last load in test_load returned 80FF7F01; stores must not touch it
        n_checks++;
        if (rdata_o !== 32'h80FF7F01) begin
            n_errors++;
            $display("FAIL store_rdata_hold: got %h want 80FF7F01", rdata_o);
        end
    endtask

    task automatic test_error;
        logic [31:0] va [5] = '{32'h33, 32'h32, 32'h30, 32'h30, 32'h31};
        logic        vw [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        logic [1:0]  vs [5] = '{2'b01, 2'b10, 2'b11, 2'b11, 2'b01};
        int lat, nce, nwe;
        logic e;
        preload(32'h30, 32'h13579BDF);
        for (int i = 0; i < 5; i++) begin
            issue(va[i], vw[i], vs[i], 1'b0, 32'hDEADBEEF, lat, e, nce, nwe);
            n_checks++;
            if (lat !== 1 || e !== 1'b1 || nce !== 0 || nwe !== 0) begin
                n_errors++;
                $display("FAIL error_resp[%0d]: got lat=%0d err=%b ce=%0d we=%0d want 1/1/0/0",
                         i, lat, e, nce, nwe);
            end
            n_checks++;
            if (rdata_o !== 32'h0) begin
                n_errors++;
                $display("FAIL error_rdata[%0d]: got %h want 00000000", i, rdata_o);
            end
        end
        n_checks++;
        if (mem[8'h0C] !== 32'h13579BDF) begin
            n_errors++;
            $display("FAIL error_ram: got %h want 13579BDF", mem[8'h0C]);
        end
    endtask

    task automatic test_back_to_back;
        logic [6:1] vmask;
        logic       rdy2;
        int         ce0;
        preload(32'h40, 32'h01020304);
        ce0 = ce_cnt;
        vmask = '0; rdy2 = 1'b1;
        req_i = 1'b1; addr_i = 32'h40; we_i = 1'b0; size_i = 2'b10; unsigned_i = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk_i); #1;
            vmask[k] = valid_o;
            if (k == 2) rdy2 = ready_o;
        end
        req_i = 1'b0;
        @(posedge clk_i); #1;
        n_checks++;
        if (vmask !== 6'b010010) begin
            n_errors++;
            $display("FAIL b2b_valid_cycles: got %b want 010010", vmask);
        end
        n_checks++;
        if (rdy2 !== 1'b0 || ce_cnt - ce0 !== 2) begin
            n_errors++;
            $display("FAIL b2b_ready_ce: got ready=%b ce=%0d want 0/2", rdy2, ce_cnt - ce0);
        end
        n_checks++;
        if (rdata_o !== 32'h01020304) begin
            n_errors++;
            $display("FAIL b2b_rdata: got %h want 01020304", rdata_o);
        end
    endtask

    task automatic test_reset_mid;
        int   lat, nce, nwe, we0;
        logic e, ce_read;
        preload(32'h50, 32'hAABBCCDD);
        we0 = we_cnt;
        req_i = 1'b1; addr_i = 32'h51; we_i = 1'b1; size_i = 2'b00; wdata_i = 32'h5A;
        @(posedge clk_i); #1;
        req_i = 1'b0;
        ce_read = ram_ce_o && !ram_we_o;
        #2 rst_ni = 1'b0;
        #1;
        n_checks++;
        if (ce_read !== 1'b1 || ram_ce_o !== 1'b0 || ram_we_o !== 1'b0 ||
            valid_o !== 1'b0 || ready_o !== 1'b1) begin
            n_errors++;
            $display("FAIL rst_mid_outputs: got read=%b ce=%b we=%b valid=%b ready=%b want 1/0/0/0/1",
                     ce_read, ram_ce_o, ram_we_o, valid_o, ready_o);
        end
        @(posedge clk_i); @(posedge clk_i); #1;
        n_checks++;
        if (mem[8'h14] !== 32'hAABBCCDD || we_cnt !== we0) begin
            n_errors++;
            $display("FAIL rst_mid_ram: got %h writes=%0d want AABBCCDD/0", mem[8'h14], we_cnt - we0);
        end
        rst_ni = 1'b1;
        @(posedge clk_i); #1;
        issue(32'h51, 1'b1, 2'b00, 1'b0, 32'h5A, lat, e, nce, nwe);
        n_checks++;
        if (lat !== 3 || e !== 1'b0 || nwe !== 1 || mem[8'h14] !== 32'hAA5ACCDD) begin
            n_errors++;
            $display("FAIL rst_mid_recover: got lat=%0d err=%b we=%0d mem=%h want 3/0/1/AA5ACCDD",
                     lat, e, nwe, mem[8'h14]);
        end
    endtask

    initial begin
        test_reset;
        test_load;
        test_store;
        test_error;
        test_back_to_back;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
